// File: rtl/seq_detect_prog.sv
// seq_detect_prog: programmable serial pattern detector with overlap control and saturating match count
//   clk         rising-edge clock
//   reset       synchronous active-high reset
//   x_i/valid_i serial data bit and its qualifier
//   cfg_load_i  strobe capturing pat_i/len_i (and mask_i when SEQ_DETECT_MASK_EN is defined)
//   pat_i       pattern, pat_i[len-1] is received first
//   len_i       pattern length in bits, legal range 2..SEQ_W
//   mask_i      don't-care bits of the pattern (only with SEQ_DETECT_MASK_EN)
//   overlap_i   1 keeps history after a match, 0 restarts the fill
//   clr_cnt_i   synchronous clear of cnt_o
//   det_o       one-cycle pulse per match, one clock after the completing bit
//   cnt_o       saturating match count
//   armed_o     high while hunting for the pattern
//   err_o       one-cycle pulse after a rejected configuration
module seq_detect_prog #(
  parameter int SEQ_W = 12,
  parameter int CNT_W = 8,
  parameter int LEN_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             x_i,
  input  logic             valid_i,
  input  logic             cfg_load_i,
  input  logic [SEQ_W-1:0] pat_i,
  input  logic [LEN_W-1:0] len_i,
`ifdef SEQ_DETECT_MASK_EN
  input  logic [SEQ_W-1:0] mask_i,
`endif
  input  logic             overlap_i,
  input  logic             clr_cnt_i,
  output logic             det_o,
  output logic [CNT_W-1:0] cnt_o,
  output logic             armed_o,
  output logic             err_o
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] HUNT = 1'b1;
  localparam logic [LEN_W-1:0] FULL = LEN_W'(SEQ_W);
  localparam logic [CNT_W-1:0] CMAX = '1;
  logic [0:0]       r_state;
  logic [SEQ_W-1:0] r_hist, r_pat;
  logic [LEN_W-1:0] r_fill, r_len;
  logic [CNT_W-1:0] r_cnt;
  logic             r_det, r_err;
  logic             w_cfg_ok, w_shift, w_match;
  logic [SEQ_W-1:0] w_hist_next, w_len_mask, w_mask;
  logic [LEN_W-1:0] w_fill_next;
`ifdef SEQ_DETECT_MASK_EN
  logic [SEQ_W-1:0] r_mask;
  assign w_mask = r_mask;
`else
  assign w_mask = '0;
`endif
  assign w_cfg_ok    = (len_i >= LEN_W'(2)) && (len_i <= FULL);
  // a load in the same cycle discards the data bit
  assign w_shift     = (r_state == HUNT) && valid_i && !cfg_load_i;
  assign w_hist_next = SEQ_W'({r_hist, x_i});
  assign w_fill_next = (r_fill == FULL) ? r_fill : r_fill + 1'b1;
  always_comb begin
    w_len_mask = '0;
    for (int i = 0; i < SEQ_W; i++) w_len_mask[i] = LEN_W'(i) < r_len;
  end
  // the current bit is already the LSB of w_hist_next, so it takes part in this compare
  assign w_match = w_shift && (w_fill_next >= r_len) &&
                   (((w_hist_next ^ r_pat) & w_len_mask & ~w_mask) == '0);
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_hist  <= '0;
      r_fill  <= '0;
      r_pat   <= '0;
      r_len   <= '0;
      r_cnt   <= '0;
      r_det   <= 1'b0;
      r_err   <= 1'b0;
`ifdef SEQ_DETECT_MASK_EN
      r_mask  <= '0;
`endif
    end else begin
      r_err <= cfg_load_i && !w_cfg_ok;
      r_det <= w_match;
      r_cnt <= clr_cnt_i ? '0 : (w_match && r_cnt != CMAX) ? r_cnt + 1'b1 : r_cnt;
      if (cfg_load_i) begin
        r_state <= w_cfg_ok ? HUNT : IDLE;
        if (w_cfg_ok) begin
          r_pat  <= pat_i;
          r_len  <= len_i;
          r_hist <= '0;
          r_fill <= '0;
`ifdef SEQ_DETECT_MASK_EN
          r_mask <= mask_i;
`endif
        end
      end else if (w_shift) begin
        r_hist <= w_hist_next;
        r_fill <= (w_match && !overlap_i) ? '0 : w_fill_next;
      end
    end
  end
  assign det_o   = r_det;
  assign cnt_o   = r_cnt;
  assign armed_o = (r_state == HUNT);
  assign err_o   = r_err;
endmodule

// File: tb/tb_seq_detect_prog.sv
// tb_seq_detect_prog: randomized and directed bench for seq_detect_prog against a bit-queue reference model
module tb_seq_detect_prog;
  logic clk = 1'b0;
  logic reset = 1'b1, x_i = 1'b0, valid_i = 1'b0, cfg_load_i = 1'b0, overlap_i = 1'b0, clr_cnt_i = 1'b0;
  logic [11:0] pat_i = '0, mask_i = '0;
  logic [4:0] len_i = '0;
  logic det_o, armed_o, err_o, det2, armed2, err2;
  logic [7:0] cnt_o;
  logic [1:0] cnt2;
  int tests = 0, fails = 0;
  bit m_armed, exp_det, exp_err;
  bit [11:0] m_pat, m_mask;
  int m_len, m_cnt, m_cnt2;
  bit m_q[$];

  always #5 clk = ~clk;

  seq_detect_prog dut (
    .clk(clk), .reset(reset), .x_i(x_i), .valid_i(valid_i), .cfg_load_i(cfg_load_i),
    .pat_i(pat_i), .len_i(len_i),
`ifdef SEQ_DETECT_MASK_EN
    .mask_i(mask_i),
`endif
    .overlap_i(overlap_i), .clr_cnt_i(clr_cnt_i),
    .det_o(det_o), .cnt_o(cnt_o), .armed_o(armed_o), .err_o(err_o));

  seq_detect_prog #(.CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .x_i(x_i), .valid_i(valid_i), .cfg_load_i(cfg_load_i),
    .pat_i(pat_i), .len_i(len_i),
`ifdef SEQ_DETECT_MASK_EN
    .mask_i(mask_i),
`endif
    .overlap_i(overlap_i), .clr_cnt_i(clr_cnt_i),
    .det_o(det2), .cnt_o(cnt2), .armed_o(armed2), .err_o(err2));

  // Model: a queue of the valid bits seen since the last (re)start; a match is the
  // last len received bits spelling the pattern from its MSB down.
  task automatic tick();
    bit hit;
    exp_det = 0;
    exp_err = 0;
    if (reset) begin
      m_armed = 0; m_pat = 0; m_len = 0; m_mask = 0; m_cnt = 0; m_cnt2 = 0;
      m_q.delete();
    end else begin
      if (cfg_load_i) begin
        if (len_i >= 2 && len_i <= 12) begin
          m_armed = 1; m_pat = pat_i; m_len = int'(len_i);
`ifdef SEQ_DETECT_MASK_EN
          m_mask = mask_i;
`else
          m_mask = 0;
`endif
          m_q.delete();
        end else begin
          m_armed = 0;
          exp_err = 1;
        end
      end else if (m_armed && valid_i) begin
        m_q.push_back(x_i);
        if (m_q.size() > 12) void'(m_q.pop_front());
        if (m_q.size() >= m_len) begin
          hit = 1;
          for (int k = 0; k < m_len; k++)
            if (!m_mask[m_len-1-k] && m_q[m_q.size()-m_len+k] != m_pat[m_len-1-k]) hit = 0;
          exp_det = hit;
          if (hit && !overlap_i) m_q.delete();
        end
      end
      if (clr_cnt_i) begin
        m_cnt = 0; m_cnt2 = 0;
      end else if (exp_det) begin
        if (m_cnt < 255) m_cnt++;
        if (m_cnt2 < 3) m_cnt2++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [11:0] p, input logic [4:0] l, input logic [11:0] m);
    pat_i = p; len_i = l; mask_i = m; cfg_load_i = 1; valid_i = 0;
    tick();
    cfg_load_i = 0;
  endtask

  task automatic send(input logic b);
    valid_i = 1; x_i = b;
    tick();
    valid_i = 0;
  endtask

  task automatic do_reset();
    reset = 1;
    tick();
    reset = 0;
  endtask

  task automatic test_reset();
    do_reset();
    tests++; if (det_o !== 1'b0) begin fails++; $display("FAIL reset_det got=%b exp=0", det_o); end
    tests++; if (cnt_o !== 8'd0) begin fails++; $display("FAIL reset_cnt got=%0d exp=0", cnt_o); end
    tests++; if (armed_o !== 1'b0) begin fails++; $display("FAIL reset_armed got=%b exp=0", armed_o); end
    tests++; if (err_o !== 1'b0) begin fails++; $display("FAIL reset_err got=%b exp=0", err_o); end
  endtask

  task automatic test_full_pattern();
    logic [11:0] p = 12'hEDB;
    overlap_i = 0;
    load(p, 5'd12, 12'h000);
    tests++; if (armed_o !== 1'b1) begin fails++; $display("FAIL full_armed got=%b exp=1", armed_o); end
    for (int i = 11; i >= 0; i--) begin
      send(p[i]);
      tests++; if (det_o !== exp_det) begin fails++; $display("FAIL full_det bit=%0d got=%b exp=%b", 11-i, det_o, exp_det); end
    end
    tests++; if (det_o !== 1'b1) begin fails++; $display("FAIL full_final_det got=%b exp=1", det_o); end
    tests++; if (cnt_o !== 8'd1) begin fails++; $display("FAIL full_cnt got=%0d exp=1", cnt_o); end
  endtask

  task automatic test_overlap();
    logic [4:0] s = 5'b10101;
    int pulses;
    for (int ov = 1; ov >= 0; ov--) begin
      overlap_i = 1'(ov);
      load(12'h005, 5'd3, 12'h000);
      pulses = 0;
      for (int i = 4; i >= 0; i--) begin
        send(s[i]);
        pulses += int'(det_o);
        tests++; if (det_o !== exp_det) begin fails++; $display("FAIL overlap%0d_det bit=%0d got=%b exp=%b", ov, 4-i, det_o, exp_det); end
      end
      tests++; if (pulses !== (ov ? 2 : 1)) begin fails++; $display("FAIL overlap%0d_pulses got=%0d exp=%0d", ov, pulses, ov ? 2 : 1); end
    end
  endtask

  task automatic test_gaps();
    logic [4:0] s = 5'b10101;
    int pulses;
    for (int ov = 1; ov >= 0; ov--) begin
      overlap_i = 1'(ov);
      load(12'h005, 5'd3, 12'h000);
      pulses = 0;
      for (int i = 4; i >= 0; i--) begin
        send(s[i]);
        pulses += int'(det_o);
        tests++; if (det_o !== exp_det) begin fails++; $display("FAIL gaps%0d_det bit=%0d got=%b exp=%b", ov, 4-i, det_o, exp_det); end
        repeat ($urandom_range(1, 3)) begin
          tick();
          tests++; if (det_o !== 1'b0) begin fails++; $display("FAIL gaps%0d_idle_det got=%b exp=0", ov, det_o); end
        end
      end
      tests++; if (pulses !== (ov ? 2 : 1)) begin fails++; $display("FAIL gaps%0d_pulses got=%0d exp=%0d", ov, pulses, ov ? 2 : 1); end
    end
  endtask

  task automatic test_bad_cfg();
    logic [4:0] bad [2] = '{5'd0, 5'd13};
    int pulses;
    overlap_i = 1;
    for (int b = 0; b < 2; b++) begin
      load(12'h005, 5'd3, 12'h000);
      load(12'h005, bad[b], 12'h000);
      tests++; if (err_o !== 1'b1) begin fails++; $display("FAIL badcfg_err len=%0d got=%b exp=1", bad[b], err_o); end
      tests++; if (armed_o !== 1'b0) begin fails++; $display("FAIL badcfg_armed len=%0d got=%b exp=0", bad[b], armed_o); end
      tick();
      tests++; if (err_o !== 1'b0) begin fails++; $display("FAIL badcfg_err_pulse len=%0d got=%b exp=0", bad[b], err_o); end
      pulses = 0;
      for (int i = 0; i < 6; i++) begin send(1'(~i)); pulses += int'(det_o); end
      tests++; if (pulses !== 0) begin fails++; $display("FAIL badcfg_det len=%0d got=%0d exp=0", bad[b], pulses); end
    end
  endtask

  task automatic test_saturate();
    do_reset();
    overlap_i = 1;
    load(12'h003, 5'd2, 12'h000);
    repeat (6) send(1'b1);
    tests++; if (cnt2 !== 2'd3) begin fails++; $display("FAIL sat_cnt2 got=%0d exp=3", cnt2); end
    tests++; if (cnt_o !== 8'd5) begin fails++; $display("FAIL sat_cnt got=%0d exp=5", cnt_o); end
    clr_cnt_i = 1;
    send(1'b1);
    clr_cnt_i = 0;
    tests++; if (det2 !== 1'b1) begin fails++; $display("FAIL clr_match_det got=%b exp=1", det2); end
    tests++; if (cnt2 !== 2'd0) begin fails++; $display("FAIL clr_match_cnt2 got=%0d exp=0", cnt2); end
    tests++; if (cnt_o !== 8'd0) begin fails++; $display("FAIL clr_match_cnt got=%0d exp=0", cnt_o); end
  endtask

  task automatic test_reset_mid();
    logic [11:0] p = 12'hEDB;
    overlap_i = 0;
    load(p, 5'd12, 12'h000);
    for (int i = 11; i >= 1; i--) send(p[i]);
    do_reset();
    tests++; if (armed_o !== 1'b0) begin fails++; $display("FAIL midreset_armed got=%b exp=0", armed_o); end
    load(p, 5'd12, 12'h000);
    send(p[0]);
    tests++; if (det_o !== 1'b0) begin fails++; $display("FAIL midreset_det got=%b exp=0", det_o); end
  endtask

`ifdef SEQ_DETECT_MASK_EN
  task automatic test_mask();
    logic [11:0] p = 12'($urandom);
    overlap_i = 0;
    load(p, 5'd12, 12'h00F);
    for (int i = 11; i >= 4; i--) send(p[i]);
    for (int i = 3; i >= 0; i--) send(1'($urandom));
    tests++; if (det_o !== 1'b1) begin fails++; $display("FAIL mask_det got=%b exp=1", det_o); end
  endtask
`endif

  task automatic test_random();
    for (int c = 0; c < 1500; c++) begin
      reset = ($urandom_range(0, 199) == 0);
      cfg_load_i = ($urandom_range(0, 39) == 0);
      pat_i = 12'($urandom);
      mask_i = ($urandom_range(0, 3) == 0) ? 12'($urandom) : 12'h000;
      len_i = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(0, 15)) : 5'($urandom_range(2, 4));
      valid_i = ($urandom_range(0, 9) < 7);
      x_i = 1'($urandom);
      overlap_i = 1'($urandom);
      clr_cnt_i = ($urandom_range(0, 49) == 0);
      tick();
      tests++; if (det_o !== exp_det) begin fails++; $display("FAIL rand_det cyc=%0d got=%b exp=%b", c, det_o, exp_det); end
      tests++; if (cnt_o !== 8'(m_cnt)) begin fails++; $display("FAIL rand_cnt cyc=%0d got=%0d exp=%0d", c, cnt_o, m_cnt); end
      tests++; if (cnt2 !== 2'(m_cnt2)) begin fails++; $display("FAIL rand_cnt2 cyc=%0d got=%0d exp=%0d", c, cnt2, m_cnt2); end
      tests++; if (armed_o !== m_armed) begin fails++; $display("FAIL rand_armed cyc=%0d got=%b exp=%b", c, armed_o, m_armed); end
      tests++; if (err_o !== exp_err) begin fails++; $display("FAIL rand_err cyc=%0d got=%b exp=%b", c, err_o, exp_err); end
    end
    reset = 0; cfg_load_i = 0; valid_i = 0; clr_cnt_i = 0;
  endtask

  initial begin
    test_reset();
    test_full_pattern();
    test_overlap();
    test_gaps();
    test_bad_cfg();
    test_saturate();
    test_reset_mid();
`ifdef SEQ_DETECT_MASK_EN
    test_mask();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/seq_detect_prog.md
SEQ_DETECT_PROG -- requirements
Module: seq_detect_prog

Interface
REQ-001 Parameter SEQ_W, default 12, maximum pattern length in bits (2..32).
REQ-002 Parameter CNT_W, default 8, width of match counter.
REQ-003 Parameter LEN_W, default 5, width of len_i; SHALL satisfy 2^LEN_W > SEQ_W.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 x_i  input  1  serial data bit, sampled only when valid_i=1.
REQ-007 valid_i  input  1  x_i qualifier; bits with valid_i=0 are ignored entirely.
REQ-008 cfg_load_i  input  1  one-cycle strobe capturing pat_i, len_i (and mask_i if compiled).
REQ-009 pat_i  input  SEQ_W  pattern; pat_i[len-1] is the first bit received, pat_i[0] the last.
REQ-010 len_i  input  LEN_W  pattern length in bits.
REQ-011 overlap_i  input  1  1 = overlapping detection, 0 = non-overlapping; sampled every cycle.
REQ-012 clr_cnt_i  input  1  synchronous clear of cnt_o.
REQ-013 det_o  output  1  one-cycle pulse per detected match.
REQ-014 cnt_o  output  CNT_W  saturating count of matches.
REQ-015 armed_o  output  1  high in HUNT state.
REQ-016 err_o  output  1  one-cycle pulse on rejected configuration.

Function
REQ-017 FSM states: IDLE (no valid pattern; bits ignored, det_o never asserts) and HUNT (detecting).
REQ-018 cfg_load_i with 2 <= len_i <= SEQ_W: capture config, clear history and fill count, next state HUNT.
REQ-019 cfg_load_i with len_i < 2 or len_i > SEQ_W: next state IDLE, err_o=1 next cycle, stored config unchanged.
REQ-020 cfg_load_i and valid_i in same cycle: load wins, x_i discarded.
REQ-021 In HUNT, each valid bit shifts into SEQ_W-bit history; fill count increments, saturating at SEQ_W.
REQ-022 Match when fill (including the current bit) >= len and the newest len history bits (current bit as LSB) equal pat[len-1:0].
REQ-023 det_o registered: asserts the cycle after the valid bit that completes a match; latency exactly 1 clk.
REQ-024 overlap_i=1: history and fill retained after match, so shared bits count toward the next match.
REQ-025 overlap_i=0: on match, fill count set to 0; the next match requires len fresh valid bits.
REQ-026 cnt_o increments on each match, saturating at 2^CNT_W-1 (no wrap).
REQ-027 clr_cnt_i coincident with a match: clear wins, cnt_o=0.
REQ-028 Bits arriving in IDLE do not alter history or fill.

Reset
REQ-029 reset=1: state IDLE, history 0, fill 0, stored pat/len/mask 0, det_o=0, cnt_o=0, armed_o=0, err_o=0.
REQ-030 reset has priority over cfg_load_i, valid_i and clr_cnt_i; mid-stream reset discards partial matches and requires reconfiguration.

Configuration
REQ-031 Macro SEQ_DETECT_MASK_EN defined: adds input mask_i [SEQ_W-1:0], captured on cfg_load_i; bit=1 makes the corresponding pattern bit don't-care in REQ-022.
REQ-032 SEQ_DETECT_MASK_EN undefined: no mask_i port; all len pattern bits compared exactly.

Verification
REQ-033 Load pat=12'hEDB (1110_1101_1011), len=12, overlap=0; feed those 12 bits MSB first, valid_i=1 -> det_o=1 one cycle after 12th bit, cnt_o=1.
REQ-034 pat=3'b101, len=3; stream 1,0,1,0,1 -> overlap=1: two det_o pulses (after bits 3 and 5); overlap=0: one pulse (after bit 3).
REQ-035 Same stream with valid_i=0 gaps between bits -> identical det_o count; pulses follow the completing valid bit by 1 clk.
REQ-036 cfg_load_i with len_i=0 and len_i=SEQ_W+1 -> err_o pulse, armed_o=0, no det_o on matching stream.
REQ-037 CNT_W=2, pat=2'b11, len=2, overlap=1, six consecutive 1s -> cnt_o saturates at 3; clr_cnt_i coincident with match -> cnt_o=0.
REQ-038 Assert reset after 11 of 12 pattern bits, then reload config and send bit 12 -> no det_o; mask build: mask=12'h00F, low 4 bits random -> det_o still asserts.
